gt_lane_deskew: RTL
===================

# gt_lane_deskew

Multi-lane receive deskew and channel-bonding block for the 7-series GTP fabric interface. It sits between N GTPE2_CHANNEL receive user ports and the link layer, with 8b10b decode and in-channel comma alignment already done in each transceiver. Per-lane elastic FIFOs line up all lanes on a common comma (K28.5) marker. It then presents one bonded, lane-aligned word stream and keeps checking alignment on every later comma.

## Interface

Parameters:
- LANES, 4, number of bonded GTP lanes (1–8)
- DATA_W, 16, decoded data bits per lane per cycle (multiple of 8; 16 matches RX_DATA_WIDTH 20)
- DEPTH, 8, per-lane FIFO entries (power of two, ≥ 4)
- MAX_SKEW, 4, maximum tolerated inter-lane skew in cycles (< DEPTH − 1)
- COMMA, 8'hBC, K-character that marks alignment (K28.5)

Ports:
- clk  in  1  RX user clock (RXUSRCLK2 domain); all lanes are synchronous to it
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  0 forces IDLE and flushes all FIFOs
- lane_data  in  LANES*DATA_W  decoded bytes; lane i occupies bits [i*DATA_W +: DATA_W]
- lane_charisk  in  LANES*DATA_W/8  per-byte K flags, same packing
- lane_valid  in  LANES  per-lane word strobe
- out_data  out  LANES*DATA_W  bonded data, same packing
- out_charisk  out  LANES*DATA_W/8  bonded K flags
- out_valid  out  1  out_data/out_charisk valid this cycle
- aligned  out  1  high in ALIGNED state
- align_err  out  1  one-cycle pulse on any alignment failure
- err_count  out  8  saturating count of align_err pulses

## Operation

- A comma word has byte 0 equal to COMMA with charisk bit 0 set. Commas in other byte positions are ignored.
- States:
  - IDLE: entered on reset or when enable is 0. FIFOs are flushed and every lane is unmarked. Goes to SEEK when enable is 1.
  - SEEK: a lane discards incoming words until it receives a comma word. That comma is written as its first FIFO entry and the lane becomes marked. After that, every valid word on the lane is written.
    - The skew counter loads 0 when the first lane is marked and increments every cycle.
    - If all lanes are marked with counter ≤ MAX_SKEW, go to ALIGNED.
    - If the counter reaches MAX_SKEW+1 with any lane still unmarked: pulse align_err, flush, unmark all lanes, stay in SEEK.
  - ALIGNED: when every FIFO is non-empty, pop all FIFOs together and register the heads to the outputs with out_valid = 1. Otherwise out_valid = 0 and nothing is popped.
- Alignment check (ALIGNED, on each pop):
  - If some popped heads are comma words and others are not: misalignment.
  - Response to misalignment: pulse align_err, out_valid = 0 for that cycle, flush, go to SEEK.
- Overflow: a write to a full FIFO in SEEK or ALIGNED counts as an alignment failure. Response is the same: align_err, flush, SEEK.
- enable falling in any state: go to IDLE next cycle, with no align_err.
- err_count increments on every align_err pulse and saturates at 255. It is cleared only by rst_n.
- Write and pop of the same FIFO in the same cycle is allowed; occupancy stays unchanged.

## Timing

- Reset values: out_data = 0, out_charisk = 0, out_valid = 0, aligned = 0, align_err = 0, err_count = 0, state = IDLE, all FIFO pointers 0.
- Inputs are sampled on the rising edge of clk.
- Last lane's comma sampled at cycle N:
  - aligned = 1 from N+1.
  - First out_valid, carrying the comma words of all lanes, at N+2.
- Steady-state latency is 2 cycles from input to out_data when lanes have zero skew. A lane with skew s sits s cycles deeper in its FIFO.
- align_err is high exactly one cycle, in the cycle after the failure is detected. aligned drops in that same cycle.
- Flush takes effect in one cycle. SEEK can accept a new comma in the cycle after the flush.
- LANES = 1: the block degenerates to a comma-gated FIFO, and misalignment can never occur.

## Test plan

- Zero skew: 4 lanes, commas at cycle 10 on all lanes, then an incrementing counter → aligned at 11; out_valid at 12 with all lanes = 16'h00BC, charisk 2'b01; then identical counters on all lanes.
- Skew 3 (lane 2 lags lane 0 by 3 cycles, MAX_SKEW = 4) → aligned after lane 2's comma; out_data lanes carry equal counter values every cycle; no align_err.
- Skew 5 with MAX_SKEW = 4 → align_err pulse when the counter reaches 5; err_count = 1; aligned stays 0; lanes re-seek; a retry with skew 2 aligns.
- In ALIGNED, inject a comma on lane 1 only → align_err the cycle after the pop; out_valid = 0; aligned = 0; state SEEK; err_count increments.
- Stall lane 3 valid for DEPTH cycles while other lanes keep writing → overflow on lane 0, align_err, flush; no out_valid during the stall.
- Assert rst_n low mid-stream and separately drop enable → all outputs at reset values (err_count kept on enable drop, zeroed on reset); realigns on the next commas.

Source files
------------

// File: rtl/gt_lane_deskew.sv
// Multi-lane receive deskew: per-lane elastic FIFOs line every lane up on a common
// K28.5 comma word, then emit one bonded word stream and recheck alignment on each comma.
module gt_lane_deskew #(
    parameter int          LANES    = 4,
    parameter int          DATA_W   = 16,
    parameter int          DEPTH    = 8,
    parameter int          MAX_SKEW = 4,
    parameter logic [7:0]  COMMA    = 8'hBC
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic [LANES*DATA_W-1:0]        lane_data,
    input  logic [LANES*(DATA_W/8)-1:0]    lane_charisk,
    input  logic [LANES-1:0]               lane_valid,
    output logic [LANES*DATA_W-1:0]        out_data,
    output logic [LANES*(DATA_W/8)-1:0]    out_charisk,
    output logic                           out_valid,
    output logic                           aligned,
    output logic                           align_err,
    output logic [7:0]                     err_count
);

    localparam int KW = DATA_W / 8;
    localparam int EW = DATA_W + KW;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEEK    = 2'd1,
        ALIGNED = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [EW-1:0]              mem [LANES][DEPTH];
    logic [LANES-1:0][AW:0]     wr_ptr;
    logic [LANES-1:0][AW:0]     rd_ptr;
    logic [LANES-1:0][EW-1:0]   head;
    logic [LANES-1:0]           marked;
    logic [LANES-1:0]           next_marked;
    logic [LANES-1:0]           mark_now;
    logic [LANES-1:0]           in_comma;
    logic [LANES-1:0]           head_comma;
    logic [LANES-1:0]           empty;
    logic [LANES-1:0]           full;
    logic [LANES-1:0]           wr_req;
    logic [LANES-1:0]           overflow_lane;
    logic [LANES*DATA_W-1:0]    head_data;
    logic [LANES*KW-1:0]        head_k;
    logic [7:0]                 skew_cnt;
    logic [7:0]                 skew_cnt_inc;
    logic                       pop;
    logic                       misalign;
    logic                       overflow;
    logic                       skew_fail;
    logic                       fail;
    logic                       flush;

    // Only byte 0 of a lane word can carry the alignment comma.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign in_comma[i]   = lane_charisk[i*KW] && (lane_data[i*DATA_W +: 8] == COMMA);
        assign head[i]       = mem[i][rd_ptr[i][AW-1:0]];
        assign head_comma[i] = head[i][DATA_W] && (head[i][7:0] == COMMA);
        assign empty[i]      = (wr_ptr[i] == rd_ptr[i]);
        assign full[i]       = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                               (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
        assign mark_now[i]   = (state == SEEK) && lane_valid[i] && !marked[i] && in_comma[i];
        assign wr_req[i]     = lane_valid[i] &&
                               (((state == SEEK) && (marked[i] || in_comma[i])) ||
                                (state == ALIGNED));
        assign overflow_lane[i] = wr_req[i] && full[i] && !pop;
        assign head_data[i*DATA_W +: DATA_W] = head[i][DATA_W-1:0];
        assign head_k[i*KW +: KW]            = head[i][DATA_W +: KW];
    end

    assign next_marked  = marked | mark_now;
    assign skew_cnt_inc = skew_cnt + 8'd1;
    assign pop          = (state == ALIGNED) && (&(~empty));
    assign misalign     = pop && (|head_comma) && !(&head_comma);
    assign overflow     = |overflow_lane;
    // A lane already marked in SEEK means at least one lane is still missing its comma.
    assign skew_fail    = (state == SEEK) && (|marked) && (skew_cnt_inc > 8'(MAX_SKEW));
    assign fail         = enable && (overflow || misalign || skew_fail);
    assign flush        = !enable || fail || (state == IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a dropped enable overrides everything without raising an error.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = SEEK;
            SEEK:    if (!fail && (&next_marked)) state_next = ALIGNED;
            ALIGNED: if (fail) state_next = SEEK;
            default: state_next = IDLE;
        endcase
        if (!enable) begin
            state_next = IDLE;
        end
    end

    // FIFO pointers, lane marks and the skew window counter; flush clears them all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            marked   <= '0;
            skew_cnt <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            marked   <= '0;
            skew_cnt <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_req[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop)       rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
            marked   <= (state == SEEK) ? next_marked : '0;
            skew_cnt <= ((state == SEEK) && (|marked)) ? skew_cnt_inc : 8'd0;
        end
    end

    // FIFO storage holds {charisk, data} per entry and needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_req[i] && !flush) begin
                mem[i][wr_ptr[i][AW-1:0]] <= {lane_charisk[i*KW +: KW],
                                              lane_data[i*DATA_W +: DATA_W]};
            end
        end
    end

    // Registered outputs; a misaligned pop is suppressed rather than forwarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data    <= '0;
            out_charisk <= '0;
            out_valid   <= 1'b0;
            aligned     <= 1'b0;
            align_err   <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            align_err <= fail;
            aligned   <= (state_next == ALIGNED);
            out_valid <= enable && pop && !misalign;
            if (fail && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (!enable) begin
                out_data    <= '0;
                out_charisk <= '0;
            end else if (pop && !misalign) begin
                out_data    <= head_data;
                out_charisk <= head_k;
            end
        end
    end

endmodule
